fp8_e5m2_accumulator: RTL and testbench



---
 rtl/fp8_pkg.sv | 26 ++
 rtl/fp8_e5m2_to_fixed.sv | 33 +++
 rtl/fp8_e5m2_accumulator.sv | 153 +++++++++++++++
 tb/tb_fp8_e5m2_accumulator.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fp8_pkg.sv
// Shared E5M2 format constants, field positions and the accumulator FSM encoding.
package fp8_pkg;

    localparam int E        = 5;
    localparam int MA       = 2;
    localparam int N        = 8;
    localparam int EXP_BIAS = 15;
    localparam int FRAC_LSB = 16;

    localparam int SIGN_BIT = 7;
    localparam int EXP_MSB  = 6;
    localparam int EXP_LSB  = 2;
    localparam int MANT_MSB = 1;
    localparam int MANT_LSB = 0;

    localparam logic [E-1:0]    EXP_INF        = 5'b11111;
    localparam logic [E+MA-1:0] MAX_FINITE_MAG = 7'b11110_11;

    typedef enum logic [1:0] {
        ST_ACC   = 2'd0,
        ST_NORM  = 2'd1,
        ST_ROUND = 2'd2,
        ST_OUT   = 2'd3
    } state_e;

endpackage

// File: rtl/fp8_e5m2_to_fixed.sv
// Unpacks one E5M2 value into a signed fixed-point word (LSB = 2^-16).
// Zero/denormal exponents map to 0; the all-ones exponent raises is_inf_o instead.
module fp8_e5m2_to_fixed
    import fp8_pkg::*;
#(
    parameter int ACC_W = 40
) (
    input  logic [N-1:0]            data_i,
    output logic signed [ACC_W-1:0] fixed_o,
    output logic                    is_inf_o
);

    logic [E-1:0]     exp_f;
    logic [MA-1:0]    mant_f;
    logic [ACC_W-1:0] mag;

    assign exp_f  = data_i[EXP_MSB:EXP_LSB];
    assign mant_f = data_i[MANT_MSB:MANT_LSB];

    always_comb begin
        mag      = '0;
        fixed_o  = '0;
        is_inf_o = 1'b0;
        if (exp_f == EXP_INF) begin
            is_inf_o = 1'b1;
        end else if (exp_f != '0) begin
            // {1,mant} already carries a 2^2 scale, so exp-1 lands on the 2^-16 grid
            mag     = ACC_W'({1'b1, mant_f}) << (exp_f - E'(1));
            fixed_o = data_i[SIGN_BIT] ? -$signed(mag) : $signed(mag);
        end
    end

endmodule

// File: rtl/fp8_e5m2_accumulator.sv
// Exact fixed-point reduction of an E5M2 product stream, with sequential
// normalisation and round-to-nearest-even back to one E5M2 result.
module fp8_e5m2_accumulator
    import fp8_pkg::*;
#(
    parameter int ACC_W = 40,
    parameter int BIAS  = 15
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] in_data,
    input  logic         in_valid,
    input  logic         in_last,
    output logic         in_ready,
    output logic [N-1:0] out_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         out_ovf
);

    localparam int CNT_W = $clog2(ACC_W);

    logic signed [ACC_W-1:0] term;
    logic                    term_inf;
    logic signed [ACC_W-1:0] acc_q;
    logic signed [ACC_W-1:0] acc_d;
    logic [ACC_W-1:0]        acc_abs;
    logic                    ovf_q;
    state_e                  state_q;
    logic [N-1:0]            out_data_q;
    logic                    out_valid_q;
    logic                    out_ovf_q;
    logic                    in_ready_q;
    logic [ACC_W-1:0]        mag_q;
    logic                    sgn_q;
    logic [CNT_W-1:0]        cnt_q;
    logic                    accept;
    logic                    load_norm;
    logic                    shift_norm;
    logic [N:0]              rounded;

    // Returns {saturated, e5m2}. mag is left-justified, c is the shift count applied.
    function automatic logic [N:0] round_e5m2(
        input logic [ACC_W-1:0] m,
        input logic [CNT_W-1:0] c,
        input logic             s,
        input logic             sat_in
    );
        logic [MA-1:0]    mant;
        logic             g;
        logic             st;
        logic             up;
        logic [MA:0]      mant_r;
        logic signed [9:0] be;
        mant   = m[ACC_W-2 -: MA];
        g      = m[ACC_W-4];
        st     = |m[ACC_W-5:0];
        up     = g & (st | mant[0]);
        mant_r = {1'b0, mant} + {{MA{1'b0}}, up};
        be     = $signed(10'(ACC_W - 1 - FRAC_LSB + BIAS))
               - $signed({{(10-CNT_W){1'b0}}, c})
               + $signed({9'b0, mant_r[MA]});
        if (sat_in)
            return {1'b1, s, MAX_FINITE_MAG};
        else if (m == '0)
            return '0;
        else if (be >= 10'sd31)
            return {1'b1, s, MAX_FINITE_MAG};
        else if (be < 10'sd1)
            return '0;
        else
            return {1'b0, s, be[E-1:0], mant_r[MA-1:0]};
    endfunction

    fp8_e5m2_to_fixed #(
        .ACC_W (ACC_W)
    ) u_to_fixed (
        .data_i   (in_data),
        .fixed_o  (term),
        .is_inf_o (term_inf)
    );

    assign accept     = in_valid & in_ready_q;
    assign acc_d      = acc_q + term;
    assign acc_abs    = acc_d[ACC_W-1] ? $unsigned(-acc_d) : $unsigned(acc_d);
    assign load_norm  = (state_q == ST_ACC) && accept && in_last;
    assign shift_norm = (state_q == ST_NORM) && (mag_q != '0) && !mag_q[ACC_W-1];
    assign rounded    = round_e5m2(mag_q, cnt_q, sgn_q, ovf_q);

    assign in_ready  = in_ready_q;
    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign out_ovf   = out_ovf_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_ACC;
            acc_q       <= '0;
            ovf_q       <= 1'b0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_ovf_q   <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            case (state_q)
                ST_ACC: begin
                    if (accept) begin
                        acc_q <= acc_d;
                        if (term_inf)
                            ovf_q <= 1'b1;
                        if (in_last) begin
                            in_ready_q <= 1'b0;
                            state_q    <= ST_NORM;
                        end
                    end
                end
                ST_NORM: begin
                    if (mag_q == '0 || mag_q[ACC_W-1])
                        state_q <= ST_ROUND;
                end
                ST_ROUND: begin
                    out_ovf_q   <= rounded[N];
                    out_data_q  <= rounded[N-1:0];
                    out_valid_q <= 1'b1;
                    state_q     <= ST_OUT;
                end
                ST_OUT: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        acc_q       <= '0;
                        ovf_q       <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= ST_ACC;
                    end
                end
                default: state_q <= ST_ACC;
            endcase
        end
    end

    // Normaliser datapath: only meaningful while the FSM sits in NORM/ROUND.
    always_ff @(posedge clk) begin
        if (load_norm) begin
            mag_q <= acc_abs;
            sgn_q <= acc_d[ACC_W-1];
            cnt_q <= '0;
        end else if (shift_norm) begin
            mag_q <= mag_q << 1;
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_fp8_e5m2_accumulator.sv
// Self-checking bench: directed vector table, reset/backpressure sequences and
// randomized vectors against a real-arithmetic reference model.
module tb_fp8_e5m2_accumulator;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_last;
    logic       in_ready;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic       out_ovf;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fp8_e5m2_accumulator #(
        .ACC_W (40),
        .BIAS  (15)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_ovf   (out_ovf)
    );

    typedef struct {
        logic [31:0] t;    // terms, first term in the low byte
        int          n;
        logic [7:0]  ed;
        logic        eo;
        int          el;   // expected latency in cycles, -1 = not checked
    } vec_t;

    vec_t vecs[11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic timeout_fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: timed out waiting on DUT", name);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_term(input logic [7:0] d, input bit last);
        int k;
        k = 0;
        in_data  = d;
        in_valid = 1'b1;
        in_last  = last;
        while (!in_ready && k < 200) begin
            tick();
            k++;
        end
        if (!in_ready) timeout_fail("send_term");
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic get_result(input int stall, output logic [7:0] d, output logic o, output int lat);
        lat = 0;
        while (!out_valid && lat < 200) begin
            tick();
            lat++;
        end
        if (!out_valid) timeout_fail("get_result");
        repeat (stall) tick();
        d = out_data;
        o = out_ovf;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    function automatic real pow2(input int e);
        real r;
        r = 1.0;
        if (e >= 0) for (int i = 0; i < e; i++) r = r * 2.0;
        else        for (int i = 0; i < -e; i++) r = r / 2.0;
        return r;
    endfunction

    function automatic real e5m2_val(input logic [7:0] b);
        int  ex;
        real v;
        ex = int'(b[6:2]);
        if (ex == 0 || ex == 31) return 0.0;
        v = (1.0 + real'(b[1:0]) / 4.0) * pow2(ex - 15);
        return b[7] ? -v : v;
    endfunction

    // Reference: exact real sum -> E5M2 with RNE, saturation and underflow to +0.
    function automatic logic [8:0] model(input real v, input bit inf);
        bit         s;
        real        a;
        real        q;
        real        fr;
        int         e;
        int         fl;
        logic [4:0] be;
        logic [1:0] mt;
        s = (v < 0.0);
        if (inf) return {1'b1, s, 7'h7B};
        if (v == 0.0) return 9'h000;
        a = s ? -v : v;
        e = 0;
        while (a >= 2.0) begin a = a / 2.0; e++; end
        while (a < 1.0)  begin a = a * 2.0; e--; end
        q  = a * 4.0;
        fl = int'($floor(q));
        fr = q - real'(fl);
        if (fr > 0.5 || (fr == 0.5 && (fl % 2) == 1)) fl++;
        if (fl == 8) begin fl = 4; e++; end
        if (e + 15 >= 31) return {1'b1, s, 7'h7B};
        if (e + 15 < 1)   return 9'h000;
        be = 5'(e + 15);
        mt = 2'(fl);
        return {1'b0, s, be, mt};
    endfunction

    initial begin
        logic [7:0] d;
        logic       o;
        int         lat;
        int         seen;

        rst       = 1'b1;
        in_data   = 8'h00;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b0;

        #3;
        check("rst_in_ready",  32'(in_ready),  32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data",  32'(out_data),  32'h00);
        check("rst_out_ovf",   32'(out_ovf),   32'd0);
        tick();
        tick();
        rst = 1'b0;
        tick();

        // 1.0 lands at fixed bit 16, so normalisation takes 39-16=23 shifts -> 25 cycles.
        vecs[0]  = '{32'h00003C3C, 2, 8'h40, 1'b0, -1};
        vecs[1]  = '{32'h0000BC3C, 2, 8'h00, 1'b0, -1};
        vecs[2]  = '{32'h0000303C, 2, 8'h3C, 1'b0, -1};
        vecs[3]  = '{32'h0000303D, 2, 8'h3E, 1'b0, -1};
        vecs[4]  = '{32'h00007B7B, 2, 8'h7B, 1'b1, -1};
        vecs[5]  = '{32'h0000FBFB, 2, 8'hFB, 1'b1, -1};
        vecs[6]  = '{32'h0000007C, 1, 8'h7B, 1'b1, 2};
        vecs[7]  = '{32'h00000001, 1, 8'h00, 1'b0, 2};
        vecs[8]  = '{32'h0000003C, 1, 8'h3C, 1'b0, 25};
        vecs[9]  = '{32'h00000004, 1, 8'h04, 1'b0, 39};
        vecs[10] = '{32'h0000B0BD, 2, 8'hBE, 1'b0, -1};

        for (int i = 0; i < 11; i++) begin
            for (int j = 0; j < vecs[i].n; j++)
                send_term(vecs[i].t[8*j +: 8], j == vecs[i].n - 1);
            get_result(0, d, o, lat);
            check($sformatf("vec%0d_data", i), 32'(d), 32'(vecs[i].ed));
            check($sformatf("vec%0d_ovf", i),  32'(o), 32'(vecs[i].eo));
            if (vecs[i].el >= 0)
                check($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].el));
        end

        // Output backpressure
        send_term(8'h3C, 1'b0);
        send_term(8'h3C, 1'b1);
        seen = 0;
        while (!out_valid && seen < 200) begin tick(); seen++; end
        if (!out_valid) timeout_fail("bp_wait");
        for (int c = 0; c < 10; c++) begin
            check("bp_out_valid", 32'(out_valid), 32'd1);
            check("bp_out_data",  32'(out_data),  32'h40);
            check("bp_in_ready",  32'(in_ready),  32'd0);
            tick();
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("bp_release_valid", 32'(out_valid), 32'd0);
        check("bp_release_ready", 32'(in_ready),  32'd1);
        tick();
        check("bp_single_handshake", 32'(out_valid), 32'd0);

        // Reset mid-vector, including a pending overflow flag
        send_term(8'h3C, 1'b0);
        send_term(8'h7C, 1'b0);
        send_term(8'h3C, 1'b0);
        #1;
        rst = 1'b1;
        #1;
        check("mid_rst_in_ready",  32'(in_ready),  32'd1);
        check("mid_rst_out_valid", 32'(out_valid), 32'd0);
        tick();
        tick();
        rst = 1'b0;
        tick();
        send_term(8'h3C, 1'b1);
        get_result(0, d, o, lat);
        check("mid_rst_next_data", 32'(d), 32'h3C);
        check("mid_rst_next_ovf",  32'(o), 32'd0);

        // Reset while normalising a tiny magnitude
        send_term(8'h04, 1'b1);
        repeat (5) tick();
        check("norm_busy_in_ready", 32'(in_ready), 32'd0);
        rst = 1'b1;
        #1;
        check("norm_rst_in_ready",  32'(in_ready),  32'd1);
        check("norm_rst_out_valid", 32'(out_valid), 32'd0);
        tick();
        rst = 1'b0;
        seen = 0;
        for (int c = 0; c < 50; c++) begin
            if (out_valid) seen++;
            tick();
        end
        check("norm_rst_no_emit", 32'(seen), 32'd0);
        send_term(8'h3C, 1'b1);
        get_result(0, d, o, lat);
        check("norm_rst_next_data", 32'(d), 32'h3C);
        check("norm_rst_next_ovf",  32'(o), 32'd0);

        // Randomized vectors against the real-arithmetic model
        for (int v = 0; v < 40; v++) begin
            int          n;
            real         sum;
            bit          inf;
            logic [7:0]  b;
            logic [8:0]  exp9;
            n   = int'($urandom_range(1, 6));
            sum = 0.0;
            inf = 1'b0;
            for (int j = 0; j < n; j++) begin
                b = 8'($urandom);
                if (b[6:2] == 5'd31) inf = 1'b1;
                sum = sum + e5m2_val(b);
                repeat ($urandom_range(0, 2)) tick();
                send_term(b, j == n - 1);
            end
            exp9 = model(sum, inf);
            get_result(int'($urandom_range(0, 3)), d, o, lat);
            check($sformatf("rand%0d", v), 32'({o, d}), 32'(exp9));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
